// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX path (and the future RX path).
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO: push is dropped when full, pop is dropped when empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     loop_clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge loop_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
            else if (!do_push && do_pop) cnt <= cnt - (AW+1)'(1);
        end
    end

    always_ff @(posedge loop_clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: byte FIFO feeding an 8N1 / 8E1 serialiser with a per-frame baud divisor.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int PARITY_EN  = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_en_i,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic [UART_DATA_BITS-1:0]     tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    uart_tx_state_e              state_q;
    logic [UART_DATA_BITS-1:0]   shift_q;
    logic [2:0]                  bit_idx_q;
    logic [DIV_W-1:0]            div_q;
    logic [DIV_W-1:0]            cnt_q;
    logic                        parity_q;
    logic                        tx_q;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_pop;
    logic [UART_DATA_BITS-1:0]   fifo_rdata;
    logic                        bit_done;

    assign fifo_pop = (state_q == IDLE) && !fifo_empty && cfg_en_i;
    assign bit_done = (cnt_q == '0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .loop_clk (clk_i),
        .rst      (rst_i),
        .push     (tx_valid_i),
        .wdata    (tx_data_i),
        .pop      (fifo_pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count_o)
    );

    // Control: each state holds tx_q for div_q+1 cycles, advancing when cnt_q hits 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tx_q      <= UART_IDLE_LEVEL;
            cnt_q     <= '0;
            bit_idx_q <= '0;
        end else begin
            if (state_q != IDLE && !bit_done) cnt_q <= cnt_q - DIV_W'(1);
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        state_q <= START;
                        tx_q    <= 1'b0;
                        cnt_q   <= cfg_div_i;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                        cnt_q     <= div_q;
                        bit_idx_q <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_q <= div_q;
                        if (bit_idx_q == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state_q <= PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= UART_IDLE_LEVEL;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state_q <= STOP;
                        tx_q    <= UART_IDLE_LEVEL;
                        cnt_q   <= div_q;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state_q <= IDLE;
                        tx_q    <= UART_IDLE_LEVEL;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= UART_IDLE_LEVEL;
                end
            endcase
        end
    end

    // Frame data: loaded on pop, shifted so shift_q[1] is always the next data bit
    always_ff @(posedge clk_i) begin
        if (fifo_pop) begin
            shift_q  <= fifo_rdata;
            div_q    <= cfg_div_i;
            parity_q <= uart_even_parity(fifo_rdata);
        end else if (state_q == DATA && bit_done) begin
            shift_q  <= shift_q >> 1;
        end
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = !fifo_full;
    assign busy_o     = (state_q != IDLE) || !fifo_empty;

endmodule
